// File: rtl/reg_bank_pkg.sv
// Shared types and op encodings for the multi-source register bank.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

package reg_bank_pkg;

    // Register operation codes applied to the addressed register.
    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_CLEAR = 3'd2,
        OP_INC   = 3'd3,
        OP_DEC   = 3'd4,
        OP_SHL   = 3'd5,
        OP_SHR   = 3'd6,
        OP_ROL   = 3'd7
    } reg_op_t;

    localparam int OP_W = 3;

    // True for every op that writes a register and updates the flags.
    function automatic logic op_writes(reg_op_t op);
        return op != OP_HOLD;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Control, data and flag bundle between the controller and the register bank.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int n       = `DEFAULT_WIDTH,
    parameter int DEPTH   = 4,
    parameter int SOURCES = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter int SW      = $clog2(SOURCES)
);
    reg_op_t              op;
    logic [AW-1:0]        waddr;
    logic [SW-1:0]        select;
    logic [SOURCES*n-1:0] in;
    logic [AW-1:0]        raddr_a;
    logic [AW-1:0]        raddr_b;
    logic [n-1:0]         out_a;
    logic [n-1:0]         out_b;
    logic                 carry;
    logic                 zero;

    modport master (
        output op, waddr, select, in, raddr_a, raddr_b,
        input  out_a, out_b, carry, zero
    );

    modport slave (
        input  op, waddr, select, in, raddr_a, raddr_b,
        output out_a, out_b, carry, zero
    );
endinterface

// File: rtl/reg_bank_alu.sv
// Combinational next-value / next-carry logic for one register operation.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int n = 8
) (
    input  reg_op_t      op,
    input  logic [n-1:0] cur,
    input  logic [n-1:0] src,
    input  logic         carry,
    input  logic         src_valid,
    output logic [n-1:0] nxt,
    output logic         nxt_carry,
    output logic         we
);

    // Decode the op into the new register value, the new carry and a write strobe.
    always_comb begin
        nxt       = cur;
        nxt_carry = carry;
        we        = op_writes(op);
        case (op)
            OP_HOLD: begin
                nxt       = cur;
                nxt_carry = carry;
            end
            OP_LOAD: begin
                // An out-of-range select loads 0 rather than an undefined bus.
                nxt       = src_valid ? src : '0;
                nxt_carry = 1'b0;
            end
            OP_CLEAR: begin
                nxt       = '0;
                nxt_carry = 1'b0;
            end
            OP_INC: begin
                nxt       = cur + n'(1);
                nxt_carry = &cur;
            end
            OP_DEC: begin
                nxt       = cur - n'(1);
                nxt_carry = ~|cur;
            end
            OP_SHL: begin
                nxt       = {cur[n-2:0], 1'b0};
                nxt_carry = cur[n-1];
            end
            OP_SHR: begin
                nxt       = {1'b0, cur[n-1:1]};
                nxt_carry = cur[0];
            end
            OP_ROL: begin
                // Rotate through carry: the old carry enters at bit 0.
                nxt       = {cur[n-2:0], carry};
                nxt_carry = cur[n-1];
            end
            default: begin
                nxt       = cur;
                nxt_carry = carry;
                we        = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_bank.sv
// Multi-source register bank: DEPTH registers, one op per cycle, two async read ports,
// registered carry and zero flags.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int n       = `DEFAULT_WIDTH,
    parameter int DEPTH   = 4,
    parameter int SOURCES = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter int SW      = $clog2(SOURCES)
) (
    input  logic       clock,
    input  logic       reset,
    reg_bank_if.slave  bus
);

    // Limits sized one bit wider than the address/select so the compare is exact.
    localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];
    localparam logic [SW:0] SRC_LIM   = SOURCES[SW:0];

    logic [DEPTH-1:0][n-1:0] regs;
    logic                    carry_q;
    logic                    zero_q;

    logic         waddr_ok;
    logic         src_valid;
    logic [n-1:0] cur;
    logic [n-1:0] src;
    logic [n-1:0] nxt;
    logic         nxt_carry;
    logic         alu_we;
    logic         wr;

    // Range checks for non-power-of-two DEPTH / SOURCES.
    always_comb begin
        waddr_ok  = {1'b0, bus.waddr} < DEPTH_LIM;
        src_valid = {1'b0, bus.select} < SRC_LIM;
    end

    // Source mux; an unmatched select leaves src at 0.
    always_comb begin
        src = '0;
        for (int k = 0; k < SOURCES; k++)
            if (bus.select == SW'(k))
                src = bus.in[k*n +: n];
    end

    // Current value of the write target; 0 when the address is out of range.
    always_comb begin
        cur = '0;
        for (int i = 0; i < DEPTH; i++)
            if (bus.waddr == AW'(i))
                cur = regs[i];
    end

    reg_bank_alu #(.n(n)) u_alu (
        .op        (bus.op),
        .cur       (cur),
        .src       (src),
        .carry     (carry_q),
        .src_valid (src_valid),
        .nxt       (nxt),
        .nxt_carry (nxt_carry),
        .we        (alu_we)
    );

    assign wr = alu_we & waddr_ok;

    // Register array: only the addressed register is written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wr && bus.waddr == AW'(i))
                    regs[i] <= nxt;
        end
    end

    // Flags follow every accepted write; zero resets low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (wr) begin
            carry_q <= nxt_carry;
            zero_q  <= (nxt == '0);
        end
    end

    // Read ports: no write bypass, out-of-range addresses read 0.
    always_comb begin
        bus.out_a = '0;
        bus.out_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr_a == AW'(i)) bus.out_a = regs[i];
            if (bus.raddr_b == AW'(i)) bus.out_b = regs[i];
        end
    end

    // Flag outputs.
    always_comb begin
        bus.carry = carry_q;
        bus.zero  = zero_q;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-source register bank: `DEPTH` registers of `n` bits, each written from one of `SOURCES` input buses or updated in place by a small set of register operations (clear, increment, decrement, shift, rotate). It is the general-purpose storage element of the datapath, replacing the single fixed four-input load register. It provides two combinational read ports, a registered carry flag and a registered zero flag for the controller.

## Interface
Parameters:
- `n`, default `` `DEFAULT_WIDTH ``: data width in bits; must be ≥ 2.
- `DEPTH`, default 4: number of registers; must be ≥ 2.
- `SOURCES`, default 4: number of input buses; must be ≥ 2.
- `AW`, default `$clog2(DEPTH)`: address width (derived).
- `SW`, default `$clog2(SOURCES)`: select width (derived).

Ports:
- `clock`  in  1  clock; rising edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  3  operation code, applied to register `waddr`.
- `waddr`  in  AW  target register for `op`.
- `select`  in  SW  source index used by LOAD.
- `in`  in  SOURCES*n  flattened sources; source k occupies bits [k*n +: n].
- `raddr_a`, `raddr_b`  in  AW  read addresses.
- `out_a`, `out_b`  out  n  contents of the addressed registers (combinational).
- `carry`  out  1  registered carry/borrow flag.
- `zero`  out  1  registered flag; 1 when the last written result was 0.

## Operation
- Op codes:
  - 0 HOLD: no register or flag change.
  - 1 LOAD: r ← in[select]; carry ← 0.
  - 2 CLEAR: r ← 0; carry ← 0.
  - 3 INC: r ← r+1 mod 2^n; carry ← 1 iff r was all-ones.
  - 4 DEC: r ← r−1 mod 2^n; carry ← 1 iff r was 0 (borrow).
  - 5 SHL: r ← {r[n-2:0],0}; carry ← r[n-1].
  - 6 SHR: r ← {0,r[n-1:1]}; carry ← r[0].
  - 7 ROL: r ← {r[n-2:0],carry}; carry ← r[n-1]. This is rotate through carry.
- Flags and width:
  - For every op except HOLD: zero ← (new r == 0).
  - Arithmetic is n-bit unsigned; wrap-around is silent apart from the carry flag.
- Boundary conditions:
  - `waddr` ≥ DEPTH (non-power-of-two DEPTH): the write is ignored and both flags hold.
  - `select` ≥ SOURCES: LOAD writes 0 and sets zero ← 1.
  - `raddr` ≥ DEPTH: the read port returns 0.
  - Only one register changes per cycle; all other registers hold.

## Timing
- Reset (asynchronous):
  - All registers, `carry` and `zero` are forced to 0 immediately; `zero` resets to 0, not 1.
  - `reset` overrides any op in flight, including during the edge on which it deasserts.
  - The first op takes effect on the first rising edge with `reset` low.
- Write latency: the op is sampled on the rising edge; the new register value and flags are visible right after that edge (1 cycle).
- Read:
  - `out_a`/`out_b` are pure combinational functions of `raddr` and register state; there is no write bypass.
  - A read of `waddr` in the same cycle as a write returns the old value; the new value appears after the edge.
- Both read ports may address the same register, and either may address `waddr`.
- Back-to-back ops on the same register chain every cycle; no stall and no hazard.
- ROL uses the `carry` value present before the edge.

## Structure
- Package `reg_bank_pkg`:
  - `typedef enum logic [2:0]` `reg_op_t` with OP_HOLD … OP_ROL.
  - Constants for the op encodings above.
- Sub-module `reg_bank_alu`:
  - Combinational.
  - Inputs: op, current value, selected source, carry, source-valid.
  - Outputs: next value, next carry, write-enable.
- Top level contains:
  - the register array;
  - the flag flops;
  - the source mux;
  - the address range checks;
  - the read muxes.

## Test plan
- Reset mid-sequence:
  - Stimulus: LOAD 8'hA5 into r2 (n=8), then assert `reset` asynchronously between edges.
  - Required response: out_a(r2)=0, carry=0, zero=0 before the next edge.
- INC wrap:
  - Stimulus: LOAD 8'hFF into r1, then INC r1.
  - Required response: r1=0, carry=1, zero=1; a following DEC r1 gives r1=8'hFF, carry=1, zero=0.
- SHL then ROL:
  - Stimulus: load 8'h81 into r0, then SHL.
  - Required response after SHL: r0=8'h02, carry=1; after ROL: r0=8'h05, carry=0.
- Read-during-write:
  - Stimulus: r3=8'h10, LOAD in[2]=8'h33 into r3 with raddr_a=raddr_b=3.
  - Required response: both ports show 8'h10 until the edge, 8'h33 after it.
- Out-of-range (DEPTH=3, SOURCES=3):
  - Stimulus: waddr=3; then select=3 LOAD into r1; then raddr_a=3.
  - Required response: the write to waddr=3 has no effect; the select=3 LOAD gives r1=0, zero=1; raddr_a=3 reads 0.
- HOLD:
  - Stimulus: 10 cycles of HOLD with random sources.
  - Required response: all registers, carry and zero unchanged.
